// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared lock-state type and default geometry for the frame syncer
package sync_pkg;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        VERIFY   = 2'd1,
        LOCKED   = 2'd2,
        FLYWHEEL = 2'd3
    } sync_state_t;

    localparam int DEF_WINDOW_SZ = 64;
    localparam int DEF_PTRN_SZ   = 8;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/frame_sync_ctrl_if.sv
// rtl/frame_sync_ctrl_if.sv - bit-stream qualifiers in, lock status and deserializer gating out
interface frame_sync_ctrl_if #(
    parameter int WINDOW_SZ = sync_pkg::DEF_WINDOW_SZ
);
    import sync_pkg::*;

    localparam int POS_W = $clog2(WINDOW_SZ);

    logic              bit_en;
    logic              pattern_hit;
    logic              payload_en;
    logic              data_valid;
    logic              in_frame;
    logic              lock_lost;
    sync_state_t       sync_state;
    logic [POS_W-1:0]  pos;

    modport master (
        output bit_en, pattern_hit,
        input  payload_en, data_valid, in_frame, lock_lost, sync_state, pos
    );

    modport slave (
        input  bit_en, pattern_hit,
        output payload_en, data_valid, in_frame, lock_lost, sync_state, pos
    );

endinterface

// File: rtl/window_counter.sv
// rtl/window_counter.sv - bit position within the frame window, wraps at WINDOW_SZ-1
module window_counter
    import sync_pkg::*;
#(
    parameter int WINDOW_SZ = DEF_WINDOW_SZ
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          clr,
    output logic [$clog2(WINDOW_SZ)-1:0]  pos,
    output logic                          boundary
);
    localparam int POS_W = $clog2(WINDOW_SZ);
    localparam logic [POS_W-1:0] LAST = POS_W'(WINDOW_SZ - 1);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            pos <= '0;
        end else if (en) begin
            pos <= (pos == LAST) ? '0 : pos + POS_W'(1);
        end
    end

    assign boundary = (pos == LAST);

endmodule

// File: rtl/frame_sync_ctrl.sv
// rtl/frame_sync_ctrl.sv - frame lock FSM: acquire, flywheel and loss decisions plus payload gating
module frame_sync_ctrl
    import sync_pkg::*;
#(
    parameter int WINDOW_SZ   = DEF_WINDOW_SZ,
    parameter int PTRN_SZ     = DEF_PTRN_SZ,
    parameter int ACQ_HITS    = 3,
    parameter int LOSS_MISSES = 3
) (
    input  logic               clk,
    input  logic               reset,
    frame_sync_ctrl_if.slave   bus
);
    localparam int POS_W   = $clog2(WINDOW_SZ);
    localparam int HIT_W   = cnt_width(ACQ_HITS);
    localparam int MISS_W  = cnt_width(LOSS_MISSES);
    localparam int PAYLOAD = WINDOW_SZ - PTRN_SZ;

    // Counter values whose increment completes a lock / loss decision.
    localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(ACQ_HITS - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_MISSES - 1);

    sync_state_t         state, state_nxt;
    logic [HIT_W-1:0]    hit_cnt, hit_cnt_nxt;
    logic [MISS_W-1:0]   miss_cnt, miss_cnt_nxt;
    logic [POS_W-1:0]    pos;
    logic                boundary;
    logic                at_bnd;
    logic                lost_nxt;
    logic                dv_nxt;
    logic                in_frame;
    logic                payload_en;
    logic                data_valid_q;
    logic                lock_lost_q;

    // HUNT keeps the window pinned at 0 so the first hit realigns it for free.
    window_counter #(.WINDOW_SZ(WINDOW_SZ)) u_window_counter (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.bit_en),
        .clr      (state == HUNT),
        .pos      (pos),
        .boundary (boundary)
    );

    assign at_bnd = bus.bit_en & boundary;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= HUNT;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            data_valid_q <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state        <= state_nxt;
            hit_cnt      <= hit_cnt_nxt;
            miss_cnt     <= miss_cnt_nxt;
            data_valid_q <= dv_nxt;
            lock_lost_q  <= lost_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        hit_cnt_nxt  = hit_cnt;
        miss_cnt_nxt = miss_cnt;
        lost_nxt     = 1'b0;
        case (state)
            HUNT: begin
                if (bus.bit_en && bus.pattern_hit) begin
                    state_nxt   = VERIFY;
                    hit_cnt_nxt = HIT_W'(1);
                end
            end
            VERIFY: begin
                if (at_bnd) begin
                    if (bus.pattern_hit) begin
                        hit_cnt_nxt = hit_cnt + HIT_W'(1);
                        if (hit_cnt == HIT_LAST) state_nxt = LOCKED;
                    end else begin
                        state_nxt   = HUNT;
                        hit_cnt_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if (at_bnd) begin
                    if (bus.pattern_hit) begin
                        miss_cnt_nxt = '0;
                    end else if (LOSS_MISSES == 1) begin
                        state_nxt    = HUNT;
                        hit_cnt_nxt  = '0;
                        miss_cnt_nxt = '0;
                        lost_nxt     = 1'b1;
                    end else begin
                        state_nxt    = FLYWHEEL;
                        miss_cnt_nxt = MISS_W'(1);
                    end
                end
            end
            FLYWHEEL: begin
                if (at_bnd) begin
                    if (bus.pattern_hit) begin
                        state_nxt    = LOCKED;
                        miss_cnt_nxt = '0;
                    end else if (miss_cnt == MISS_LAST) begin
                        state_nxt    = HUNT;
                        hit_cnt_nxt  = '0;
                        miss_cnt_nxt = '0;
                        lost_nxt     = 1'b1;
                    end else begin
                        miss_cnt_nxt = miss_cnt + MISS_W'(1);
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // A byte completes on the accepted payload bit whose low three position bits are all ones.
    always_comb begin
        in_frame   = ((state == LOCKED) || (state == FLYWHEEL)) && (pos < POS_W'(PAYLOAD));
        payload_en = bus.bit_en & in_frame;
        dv_nxt     = payload_en && (pos[2:0] == 3'b111);
    end

    assign bus.payload_en = payload_en;
    assign bus.in_frame   = in_frame;
    assign bus.data_valid = data_valid_q;
    assign bus.lock_lost  = lock_lost_q;
    assign bus.sync_state = state;
    assign bus.pos        = pos;

endmodule
